// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-port 32-bit word memory with a request/ready handshake
//            and a programmable number of wait states per access. The MAR
//            supplies the address, the MDR supplies write data and receives
//            read data.
// Ports    : clk      - clock, all state changes on the rising edge
//            clr      - asynchronous active-high reset (memory is kept)
//            addr     - word address, captured when a request is accepted
//            wr_data  - write data, captured when a request is accepted
//            read     - read request level, looked at only while idle
//            write    - write request level, looked at only while idle
//            rd_data  - registered read data, held until the next read
//            ready    - one-cycle pulse when an access completes
//            busy     - high while an access is in progress
//            err      - one-cycle pulse when read and write arrive together
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int AW          = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  input  logic          read,
  input  logic          write,
  output logic [31:0]   rd_data,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // Wait-state count loaded on acceptance; the WAIT state lasts this many
  // extra cycles before the access is carried out.
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_op_wr;
  logic [31:0]   r_rd_data;
  logic          r_ready;
  logic          r_err;

  // Storage starts at zero and is deliberately outside the reset domain,
  // so clr never disturbs its contents.
  logic [31:0]   r_mem [DEPTH] = '{default: 32'h0};

  logic          w_accept;
  logic          w_conflict;
  logic          w_complete;
  logic          w_mem_we;

  assign w_accept   = read ^ write;
  assign w_conflict = read & write;

  // The access happens on the edge that leaves WAIT with the count spent.
  // Because clr forces r_state to IDLE asynchronously, a reset during WAIT
  // removes the write enable before the next edge, aborting the access.
  assign w_complete = (r_state == c_WAIT) && (r_cnt == 4'd0);
  assign w_mem_we   = w_complete && r_op_wr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= c_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_op_wr   <= 1'b0;
      r_rd_data <= 32'h0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // ready and err are single-cycle pulses unless re-asserted below.
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            // Capture everything now so later input changes cannot leak
            // into the access in flight.
            r_addr  <= addr;
            r_wdata <= wr_data;
            r_op_wr <= write;
            r_cnt   <= c_WAIT_INIT;
            r_state <= c_WAIT;
          end else if (w_conflict) begin
            r_err   <= 1'b1;
          end
        end
        c_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_op_wr) begin
              r_rd_data <= r_mem[r_addr];
            end
            r_ready <= 1'b1;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign rd_data = r_rd_data;
  assign ready   = r_ready;
  assign err     = r_err;
  assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire
